// File: rtl/ci_issue_master.sv
// ci_issue_master
//
// Initiator side of the custom-instruction (CI) handshake. Each operand taken
// from the input stream becomes one CI transaction: a one-cycle ci_start
// pulse, ci_dataa held stable, and ci_clk_en asserted while the slave works.
// The result is captured either when the slave raises ci_done (done mode) or
// a fixed number of cycles after the start cycle (fixed mode). It is then
// presented on the output stream until the consumer accepts it.
//
// Parameters
//   FIXED_LATENCY  0 = done mode, N>0 = capture N cycles after the start cycle
//   TIMEOUT        done-mode watchdog in cycles (1..65535)
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low
//   in_valid     operand available
//   in_ready     block can accept an operand (registered)
//   in_data      operand
//   out_valid    result available
//   out_ready    consumer accepts result
//   out_data     captured result, 0 on timeout
//   out_timeout  out_data is a timeout marker
//   ci_clk_en    slave clock enable
//   ci_start     one-cycle start pulse
//   ci_dataa     operand to the slave
//   ci_result    slave result
//   ci_done      slave completion
//   txn_count    completed transactions, timeouts included (wraps)

module ci_issue_master #(
  parameter int FIXED_LATENCY = 0,
  parameter int TIMEOUT       = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_timeout,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam bit          FIXED_MODE   = (FIXED_LATENCY > 0);
  localparam logic [15:0] FIXED_LAST   = 16'(FIXED_LATENCY);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  state_t      state_next;

  logic        in_ready_reg;
  logic [31:0] ci_dataa_reg;
  logic [15:0] cycle_cnt_reg;
  logic [31:0] out_data_reg;
  logic        out_timeout_reg;
  logic [15:0] txn_count_reg;

  logic        accept;
  logic        release_out;
  logic        capture;
  logic        capture_timeout;

  assign accept      = (state_reg == IDLE) && in_valid && in_ready_reg;
  assign release_out = (state_reg == HOLD) && out_ready;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and capture decisions
  // cycle_cnt_reg equals k during cycle Ck (C0 = the ISSUE cycle).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    capture         = 1'b0;
    capture_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!FIXED_MODE && ci_done) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (!FIXED_MODE && (TIMEOUT_LAST == 16'd0)) begin
          // A one-cycle watchdog expires at the end of C0 itself.
          capture_timeout = 1'b1;
          state_next      = HOLD;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (FIXED_MODE) begin
          if (cycle_cnt_reg >= FIXED_LAST) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end else if (ci_done) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (cycle_cnt_reg >= TIMEOUT_LAST) begin
          capture_timeout = 1'b1;
          state_next      = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready_reg    <= 1'b0;
      ci_dataa_reg    <= 32'd0;
      cycle_cnt_reg   <= 16'd0;
      out_data_reg    <= 32'd0;
      out_timeout_reg <= 1'b0;
      txn_count_reg   <= 16'd0;
    end else begin
      // Ready follows the state we are about to enter, so it is low for the
      // whole transaction and rises together with the return to IDLE.
      in_ready_reg <= (state_next == IDLE);

      if (accept) begin
        ci_dataa_reg  <= in_data;
        cycle_cnt_reg <= 16'd0;
      end else if (((state_reg == ISSUE) || (state_reg == WAIT)) &&
                   (cycle_cnt_reg != 16'hFFFF)) begin
        cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
      end

      if (capture) begin
        out_data_reg    <= ci_result;
        out_timeout_reg <= 1'b0;
      end else if (capture_timeout) begin
        out_data_reg    <= 32'd0;
        out_timeout_reg <= 1'b1;
      end

      if (release_out) begin
        txn_count_reg <= txn_count_reg + 16'd1;
      end
    end
  end

  // Strobes decode straight from the state so an asynchronous reset drops
  // them in the same instant it forces IDLE.
  assign ci_start    = (state_reg == ISSUE);
  assign ci_clk_en   = (state_reg == ISSUE) || (state_reg == WAIT);
  assign out_valid   = (state_reg == HOLD);

  assign in_ready    = in_ready_reg;
  assign ci_dataa    = ci_dataa_reg;
  assign out_data    = out_data_reg;
  assign out_timeout = out_timeout_reg;
  assign txn_count   = txn_count_reg;

endmodule

// File: tb/tb_ci_issue_master.sv
// Bench for ci_issue_master. Instance 0 runs fixed mode (latency 2) against a
// stub returning dataa+1; instance 1 runs done mode (timeout 8) against a
// programmable stub. Stimulus pushes expected results into a per-instance
// queue; a per-instance monitor pops and compares on every out_valid rise.

module tb_ci_issue_master;

  typedef struct {
    logic [31:0] data;
    logic        timeout;
    int          rise;
    int          en;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        rst_n       [2];
  logic        in_valid    [2];
  logic [31:0] in_data     [2];
  logic        in_ready    [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [31:0] out_data    [2];
  logic        out_timeout [2];
  logic        ci_clk_en   [2];
  logic        ci_start    [2];
  logic [31:0] ci_dataa    [2];
  logic [15:0] txn_count   [2];

  // Slave stubs
  int          stub_k   = -1;
  logic        tie_done = 1'b0;
  logic [31:0] stub_val = 32'd0;
  int          st_cyc   = 0;
  logic [31:0] f_result;
  logic        f_done;
  logic [31:0] d_result;
  logic        d_done;

  assign f_result = ci_dataa[0] + 32'd1;
  assign f_done   = 1'b1;   // fixed mode must ignore it

  always @(posedge clock) st_cyc <= ci_start[1] ? 1 : st_cyc + 1;

  assign d_done   = tie_done ||
                    (ci_clk_en[1] && (stub_k >= 0) && ((ci_start[1] ? 0 : st_cyc) == stub_k));
  assign d_result = d_done ? stub_val : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    exp_t exp_q[$];
    int   starts[$];

    ci_issue_master #(
      .FIXED_LATENCY(gi == 0 ? 2 : 0),
      .TIMEOUT      (8)
    ) u_dut (
      .clock      (clock),
      .reset      (rst_n[gi]),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .in_data    (in_data[gi]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi]),
      .out_data   (out_data[gi]),
      .out_timeout(out_timeout[gi]),
      .ci_clk_en  (ci_clk_en[gi]),
      .ci_start   (ci_start[gi]),
      .ci_dataa   (ci_dataa[gi]),
      .ci_result  (gi == 0 ? f_result : d_result),
      .ci_done    (gi == 0 ? f_done : d_done),
      .txn_count  (txn_count[gi])
    );

    initial begin : monitor
      int          cyc;
      int          en_cnt;
      int          gcyc;
      logic        prev_ov;
      logic        prev_st;
      logic [31:0] hold_data;
      logic        hold_to;
      exp_t        e;
      cyc = 0; en_cnt = 0; gcyc = 0;
      prev_ov = 1'b0; prev_st = 1'b0;
      hold_data = 32'd0; hold_to = 1'b0;
      forever begin
        @(negedge clock);
        gcyc++;
        if (rst_n[gi] !== 1'b1) begin
          prev_ov = 1'b0;
          prev_st = 1'b0;
          en_cnt  = 0;
        end else begin
          if (ci_start[gi]) begin
            chk($sformatf("i%0d_start_consecutive", gi), 32'(prev_st), 32'd0);
            cyc    = 0;
            en_cnt = 0;
            starts.push_back(gcyc);
          end else begin
            cyc++;
          end
          if (ci_clk_en[gi]) en_cnt++;
          if (out_valid[gi] && !prev_ov) begin
            chk($sformatf("i%0d_result_expected", gi), 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk($sformatf("i%0d_out_data", gi), out_data[gi], e.data);
              chk($sformatf("i%0d_out_timeout", gi), 32'(out_timeout[gi]), 32'(e.timeout));
              chk($sformatf("i%0d_valid_cycle", gi), 32'(cyc), 32'(e.rise));
              chk($sformatf("i%0d_clk_en_cycles", gi), 32'(en_cnt), 32'(e.en));
            end
            hold_data = out_data[gi];
            hold_to   = out_timeout[gi];
          end else if (out_valid[gi]) begin
            chk($sformatf("i%0d_hold_data", gi), out_data[gi], hold_data);
            chk($sformatf("i%0d_hold_timeout", gi), 32'(out_timeout[gi]), 32'(hold_to));
          end
          prev_ov = out_valid[gi];
          prev_st = ci_start[gi];
        end
      end
    end
  end

  // Consumer: always ready, except a 10-cycle stall on the third result of
  // instance 0 (the second result of the streamed burst).
  initial begin : consumer
    logic prev;
    int   rise_n;
    prev = 1'b0;
    rise_n = 0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(negedge clock);
      if (out_valid[0] && !prev) begin
        rise_n++;
        if (rise_n == 3) begin
          out_ready[0] = 1'b0;
          for (int c = 0; c < 10; c++) begin
            chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
            chk("stall_out_valid", 32'(out_valid[0]), 32'd1);
            @(negedge clock);
          end
          out_ready[0] = 1'b1;
        end
      end
      prev = out_valid[0];
    end
  end

  task automatic push(input int i, input logic [31:0] d, input logic t, input int r, input int en);
    exp_t e;
    e.data = d; e.timeout = t; e.rise = r; e.en = en;
    if (i == 0) g_mon[0].exp_q.push_back(e);
    else        g_mon[1].exp_q.push_back(e);
  endtask

  // Present an operand and hold it until accepted (call away from posedge).
  task automatic send(input int i, input logic [31:0] d);
    int b;
    b = 0;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && b < 300) begin
      @(negedge clock);
      b++;
    end
    if (b >= 300) chk($sformatf("i%0d_accept_wait", i), 32'(in_ready[i]), 32'd1);
    @(posedge clock);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_txn(input int i, input logic [15:0] target);
    int b;
    b = 0;
    while (txn_count[i] !== target && b < 300) begin
      @(negedge clock);
      b++;
    end
    chk($sformatf("i%0d_txn_count", i), 32'(txn_count[i]), 32'(target));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < 2; i++) begin
      rst_n[i]    = 1'b0;
      in_valid[i] = 1'b0;
      in_data[i]  = 32'd0;
    end
    repeat (3) @(negedge clock);

    // Reset values
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d_rst_in_ready", i), 32'(in_ready[i]), 32'd0);
      chk($sformatf("i%0d_rst_out_valid", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("i%0d_rst_out_data", i), out_data[i], 32'd0);
      chk($sformatf("i%0d_rst_out_timeout", i), 32'(out_timeout[i]), 32'd0);
      chk($sformatf("i%0d_rst_clk_en", i), 32'(ci_clk_en[i]), 32'd0);
      chk($sformatf("i%0d_rst_start", i), 32'(ci_start[i]), 32'd0);
      chk($sformatf("i%0d_rst_dataa", i), ci_dataa[i], 32'd0);
      chk($sformatf("i%0d_rst_txn_count", i), 32'(txn_count[i]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    chk("release_in_ready_before_edge", 32'(in_ready[1]), 32'd0);
    @(posedge clock);
    #1;
    chk("i0_in_ready_after_edge", 32'(in_ready[0]), 32'd1);
    chk("i1_in_ready_after_edge", 32'(in_ready[1]), 32'd1);
    @(negedge clock);

    // Fixed-mode latency
    g_mon[0].starts.delete();
    push(0, 32'h3F800001, 1'b0, 3, 3);
    send(0, 32'h3F800000);
    wait_txn(0, 16'd1);
    chk("i0_single_start", 32'(g_mon[0].starts.size()), 32'd1);
    chk("i0_dataa_held", ci_dataa[0], 32'h3F800000);

    // Streamed burst with backpressure on the second result
    g_mon[0].starts.delete();
    push(0, 32'h40000001, 1'b0, 3, 3);
    push(0, 32'h40400001, 1'b0, 3, 3);
    push(0, 32'h00000001, 1'b0, 3, 3);
    push(0, 32'h00000000, 1'b0, 3, 3);
    send(0, 32'h40000000);
    send(0, 32'h40400000);
    send(0, 32'h00000000);
    send(0, 32'hFFFFFFFF);
    wait_txn(0, 16'd5);
    chk("i0_burst_starts", 32'(g_mon[0].starts.size()), 32'd4);
    if (g_mon[0].starts.size() == 4) begin
      chk("spacing_1_2", 32'(g_mon[0].starts[1] - g_mon[0].starts[0]), 32'd5);
      chk("spacing_2_3_stalled", 32'(g_mon[0].starts[2] - g_mon[0].starts[1]), 32'd15);
      chk("spacing_3_4", 32'(g_mon[0].starts[3] - g_mon[0].starts[2]), 32'd5);
    end

    // Done mode: timeout
    stub_k = -1;
    push(1, 32'd0, 1'b1, 8, 8);
    send(1, 32'hA5A5A5A5);
    wait_txn(1, 16'd1);

    // Done mode: done in C5
    stub_k   = 5;
    stub_val = 32'h12345678;
    push(1, 32'h12345678, 1'b0, 6, 6);
    send(1, 32'h00000005);
    wait_txn(1, 16'd2);

    // Done tied high: capture in the start cycle
    stub_k   = -1;
    tie_done = 1'b1;
    stub_val = 32'hCAFEF00D;
    push(1, 32'hCAFEF00D, 1'b0, 1, 1);
    send(1, 32'h00000007);
    wait_txn(1, 16'd3);
    tie_done = 1'b0;

    // Reset in C1 of an in-flight transaction; nothing is expected from it
    send(1, 32'h11111111);
    @(posedge clock);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("midrst_start", 32'(ci_start[1]), 32'd0);
    chk("midrst_clk_en", 32'(ci_clk_en[1]), 32'd0);
    chk("midrst_out_valid", 32'(out_valid[1]), 32'd0);
    chk("midrst_txn_count", 32'(txn_count[1]), 32'd0);
    chk("midrst_out_data", out_data[1], 32'd0);
    chk("midrst_dataa", ci_dataa[1], 32'd0);
    chk("midrst_in_ready", 32'(in_ready[1]), 32'd0);
    repeat (2) @(negedge clock);
    rst_n[1] = 1'b1;
    #1;
    chk("midrst_release_in_ready_low", 32'(in_ready[1]), 32'd0);
    @(posedge clock);
    #1;
    chk("midrst_release_in_ready_high", 32'(in_ready[1]), 32'd1);
    @(negedge clock);

    // One clean transaction after the reset
    tie_done = 1'b1;
    stub_val = 32'h0BADF00D;
    push(1, 32'h0BADF00D, 1'b0, 1, 1);
    send(1, 32'h00000009);
    wait_txn(1, 16'd1);
    tie_done = 1'b0;

    repeat (3) @(negedge clock);
    chk("i0_queue_drained", 32'(g_mon[0].exp_q.size()), 32'd0);
    chk("i1_queue_drained", 32'(g_mon[1].exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
